cpu_nb_bridge: RTL and testbench

Memory-mapped data-bus bridge between the CPU data port and the neuron bank, replacing the combinational address decode used in the CPU/neuron-bank integration bench. Decodes each CPU load/store into one of three regions: neuron bank, local scratch RAM, or unmapped. Runs a registered request/response handshake with the neuron bank, holds the CPU with BUSYWAIT until the access completes, and records bus errors for software.

---
 rtl/cpu_nb_bridge_pkg.sv | 41 ++++
 rtl/cpu_nb_bridge_if.sv | 42 ++++
 rtl/cpu_nb_bridge_dm_scratch.sv | 20 ++
 rtl/cpu_nb_bridge.sv | 152 +++++++++++++++
 tb/tb_cpu_nb_bridge.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/cpu_nb_bridge_pkg.sv
// Shared types and constants for the CPU / neuron-bank data-bus bridge.
// Includes the address-region decode used by the bridge FSM.
package bridge_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned PAGE_W = 20;

    localparam logic [DATA_W-1:0] ERR_DATA = 32'hDEAD_0BAD;

    typedef enum logic [2:0] {
        S_IDLE,
        S_NB_ISSUE,
        S_NB_WAIT,
        S_DM_WAIT,
        S_DONE
    } state_e;

    typedef enum logic [1:0] {
        REG_NB,
        REG_DM,
        REG_NONE
    } region_e;

    // Request captured in IDLE and held for the whole access.
    typedef struct packed {
        logic              write;
        logic [DATA_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } req_t;

    function automatic region_e decode_region(
        input logic [DATA_W-1:0] addr,
        input logic [PAGE_W-1:0] nb_page,
        input logic [PAGE_W-1:0] dm_page
    );
        if (addr[DATA_W-1 -: PAGE_W] == nb_page) return REG_NB;
        if (addr[DATA_W-1 -: PAGE_W] == dm_page) return REG_DM;
        return REG_NONE;
    endfunction

endpackage

// File: rtl/cpu_nb_bridge_if.sv
// CPU data-port bus and neuron-bank request bus used by cpu_nb_bridge.
interface cpu_nb_bridge_if;
    import bridge_pkg::*;

    logic              DATA_MEM_READ;
    logic              DATA_MEM_WRITE;
    logic [DATA_W-1:0] DATA_MEM_ADDR;
    logic [DATA_W-1:0] DATA_MEM_WRITE_DATA;
    logic [DATA_W-1:0] DATA_MEM_READ_DATA;
    logic              DATA_MEM_BUSYWAIT;

    modport master (
        output DATA_MEM_READ, DATA_MEM_WRITE, DATA_MEM_ADDR, DATA_MEM_WRITE_DATA,
        input  DATA_MEM_READ_DATA, DATA_MEM_BUSYWAIT
    );

    modport slave (
        input  DATA_MEM_READ, DATA_MEM_WRITE, DATA_MEM_ADDR, DATA_MEM_WRITE_DATA,
        output DATA_MEM_READ_DATA, DATA_MEM_BUSYWAIT
    );
endinterface

interface nb_bus_if #(parameter int unsigned AW = 8);
    import bridge_pkg::*;

    logic [AW-1:0]     nb_address;
    logic              nb_read_enable;
    logic              nb_write_enable;
    logic [DATA_W-1:0] nb_write_data;
    logic [DATA_W-1:0] nb_read_data;
    logic              nb_ready;

    modport master (
        output nb_address, nb_read_enable, nb_write_enable, nb_write_data,
        input  nb_read_data, nb_ready
    );

    modport slave (
        input  nb_address, nb_read_enable, nb_write_enable, nb_write_data,
        output nb_read_data, nb_ready
    );
endinterface

// File: rtl/cpu_nb_bridge_dm_scratch.sv
// Local scratch RAM: single port, synchronous write, registered read.
module dm_scratch #(
    parameter int unsigned WORDS = 256
) (
    input  logic                     CLK,
    input  logic                     we,
    input  logic [$clog2(WORDS)-1:0] addr,
    input  logic [31:0]              wdata,
    output logic [31:0]              rdata
);

    logic [31:0] mem [WORDS];

    // Contents are intentionally not reset.
    always_ff @(posedge CLK) begin
        if (we) mem[addr] <= wdata;
        rdata <= mem[addr];
    end

endmodule

// File: rtl/cpu_nb_bridge.sv
// CPU data-port bridge: decodes loads/stores to neuron bank, scratch RAM or
// unmapped space, stalls the CPU until completion and logs bus errors.
module cpu_nb_bridge
    import bridge_pkg::*;
#(
    parameter logic [19:0] NB_REGION     = 20'h80000,
    parameter logic [19:0] DM_REGION     = 20'h00000,
    parameter int unsigned NB_ADDR_WIDTH = 8,
    parameter int unsigned DM_WORDS      = 256,
    parameter int unsigned DM_LATENCY    = 2,
    parameter int unsigned TIMEOUT       = 64
) (
    input  logic              CLK,
    input  logic              RESET,
    cpu_nb_bridge_if.slave    cpu,
    nb_bus_if.master          nb,
    input  logic              err_clear,
    output logic              bus_error,
    output logic [DATA_W-1:0] err_addr
);

    localparam int unsigned DM_AW   = $clog2(DM_WORDS);
    localparam int unsigned CNT_MAX = (TIMEOUT > DM_LATENCY) ? TIMEOUT : DM_LATENCY;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    state_e            state;
    req_t              req_q;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] ram_q;

    logic              req_c;
    region_e           region_c;
    logic              dec_err_c;
    logic              timeout_c;
    logic              dm_last_c;
    logic              err_fire_c;
    logic [DATA_W-1:0] err_addr_c;
    logic              ram_we_c;
    logic [DM_AW-1:0]  ram_addr_c;

    // Request decode, completion conditions and RAM controls.
    always_comb begin
        req_c      = cpu.DATA_MEM_READ || cpu.DATA_MEM_WRITE;
        region_c   = decode_region(cpu.DATA_MEM_ADDR, NB_REGION, DM_REGION);
        dec_err_c  = (cpu.DATA_MEM_READ && cpu.DATA_MEM_WRITE) ||
                     (region_c == REG_NONE) ||
                     ((region_c == REG_DM) && (cpu.DATA_MEM_ADDR[1:0] != 2'b00));
        timeout_c  = (state == S_NB_WAIT) && !nb.nb_ready &&
                     (cnt == CNT_W'(TIMEOUT - 1));
        dm_last_c  = (state == S_DM_WAIT) && (cnt == CNT_W'(DM_LATENCY - 1));
        err_fire_c = ((state == S_IDLE) && req_c && dec_err_c) || timeout_c;
        err_addr_c = (state == S_IDLE) ? cpu.DATA_MEM_ADDR : req_q.addr;
        ram_we_c   = dm_last_c && req_q.write;
        // Read address follows the live bus in IDLE so data is ready by the last wait cycle.
        ram_addr_c = (state == S_IDLE) ? cpu.DATA_MEM_ADDR[DM_AW+1:2]
                                       : req_q.addr[DM_AW+1:2];
    end

    assign cpu.DATA_MEM_BUSYWAIT = !RESET &&
        (((state != S_IDLE) && (state != S_DONE)) || ((state == S_IDLE) && req_c));

    dm_scratch #(.WORDS(DM_WORDS)) u_dm (
        .CLK   (CLK),
        .we    (ram_we_c),
        .addr  (ram_addr_c),
        .wdata (req_q.wdata),
        .rdata (ram_q)
    );

    // Access sequencer.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state                  <= S_IDLE;
            req_q                  <= '0;
            cnt                    <= '0;
            cpu.DATA_MEM_READ_DATA <= '0;
            nb.nb_address          <= '0;
            nb.nb_read_enable      <= 1'b0;
            nb.nb_write_enable     <= 1'b0;
            nb.nb_write_data       <= '0;
        end else begin
            nb.nb_read_enable  <= 1'b0;
            nb.nb_write_enable <= 1'b0;
            case (state)
                S_IDLE: begin
                    cpu.DATA_MEM_READ_DATA <= '0;
                    if (req_c) begin
                        req_q.write <= cpu.DATA_MEM_WRITE;
                        req_q.addr  <= cpu.DATA_MEM_ADDR;
                        req_q.wdata <= cpu.DATA_MEM_WRITE_DATA;
                        cnt         <= '0;
                        if (dec_err_c) begin
                            state                  <= S_DONE;
                            cpu.DATA_MEM_READ_DATA <= ERR_DATA;
                        end else if (region_c == REG_NB) begin
                            state              <= S_NB_ISSUE;
                            nb.nb_read_enable  <= cpu.DATA_MEM_READ;
                            nb.nb_write_enable <= cpu.DATA_MEM_WRITE;
                            nb.nb_address      <= cpu.DATA_MEM_ADDR[NB_ADDR_WIDTH-1:0];
                            nb.nb_write_data   <= cpu.DATA_MEM_WRITE_DATA;
                        end else begin
                            state <= S_DM_WAIT;
                        end
                    end
                end
                S_NB_ISSUE: begin
                    state <= S_NB_WAIT;
                    cnt   <= '0;
                end
                S_NB_WAIT: begin
                    if (nb.nb_ready) begin
                        state                  <= S_DONE;
                        cpu.DATA_MEM_READ_DATA <= req_q.write ? '0 : nb.nb_read_data;
                    end else if (timeout_c) begin
                        state                  <= S_DONE;
                        cpu.DATA_MEM_READ_DATA <= ERR_DATA;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_DM_WAIT: begin
                    if (dm_last_c) begin
                        state                  <= S_DONE;
                        cpu.DATA_MEM_READ_DATA <= req_q.write ? '0 : ram_q;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_DONE: begin
                    state                  <= S_IDLE;
                    cpu.DATA_MEM_READ_DATA <= '0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Sticky error log; a new error takes priority over a clear.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            bus_error <= 1'b0;
            err_addr  <= '0;
        end else if (err_fire_c) begin
            bus_error <= 1'b1;
            if (!bus_error) err_addr <= err_addr_c;
        end else if (err_clear) begin
            bus_error <= 1'b0;
            err_addr  <= '0;
        end
    end

endmodule

// File: tb/tb_cpu_nb_bridge.sv
// Directed bench for cpu_nb_bridge: vector table of accesses plus reset sequences.
module tb_cpu_nb_bridge;

    localparam int LIMIT = 100;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        err_clear;
    logic        bus_error;
    logic [31:0] err_addr;

    cpu_nb_bridge_if cpu ();
    nb_bus_if #(.AW(8)) nb ();

    cpu_nb_bridge dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .cpu       (cpu),
        .nb        (nb),
        .err_clear (err_clear),
        .bus_error (bus_error),
        .err_addr  (err_addr)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] nb_rdata;
        int          ready_from;
        logic        clr;
        int          exp_done;
        logic [31:0] exp_data;
        int          exp_busy;
        int          exp_rdp;
        int          exp_wrp;
        int          exp_pcyc;
        logic [7:0]  exp_paddr;
        logic        exp_err;
        logic [31:0] exp_eaddr;
    } vec_t;

    vec_t vecs [12];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Runs one CPU access from an IDLE cycle; returns one cycle after completion.
    task automatic access(input vec_t v, output int done_cyc, output logic [31:0] data,
                          output int busy, output int rdp, output int wrp, output int pcyc,
                          output logic [7:0] paddr, output logic [31:0] pwd, output logic both);
        done_cyc = -1; data = '0; busy = 0; rdp = 0; wrp = 0; pcyc = -1;
        paddr = '0; pwd = '0; both = 1'b0;
        nb.nb_read_data         = v.nb_rdata;
        cpu.DATA_MEM_READ       = v.rd;
        cpu.DATA_MEM_WRITE      = v.wr;
        cpu.DATA_MEM_ADDR       = v.addr;
        cpu.DATA_MEM_WRITE_DATA = v.wd;
        for (int c = 0; c <= LIMIT; c++) begin
            nb.nb_ready = (c >= v.ready_from);
            #1;
            if (nb.nb_read_enable || nb.nb_write_enable) begin
                pcyc  = c;
                paddr = nb.nb_address;
                pwd   = nb.nb_write_data;
            end
            if (nb.nb_read_enable)  rdp++;
            if (nb.nb_write_enable) wrp++;
            if (nb.nb_read_enable && nb.nb_write_enable) both = 1'b1;
            if (!cpu.DATA_MEM_BUSYWAIT) begin
                done_cyc = c;
                data     = cpu.DATA_MEM_READ_DATA;
                break;
            end
            busy++;
            @(posedge CLK); #1;
        end
        cpu.DATA_MEM_READ  = 1'b0;
        cpu.DATA_MEM_WRITE = 1'b0;
        @(posedge CLK); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          dc, bz, rp, wp, pc;
        logic [31:0] dat, pw;
        logic [7:0]  pa;
        logic        bh;
        vec_t        v;

        //         rd    wr    addr          wd            nb_rdata      rdy   clr   done data          busy rdp wrp pcyc paddr  err   eaddr
        vecs[0]  = '{1'b0, 1'b1, 32'h8000_0010, 32'h0000_0064, 32'h0,        0,    1'b0, 3,  32'h0,        3,  0, 1,  1, 8'h10, 1'b0, 32'h0};
        vecs[1]  = '{1'b1, 1'b0, 32'h8000_0020, 32'h0,        32'h1234_5678, 7,    1'b0, 8,  32'h1234_5678, 8,  1, 0,  1, 8'h20, 1'b0, 32'h0};
        vecs[2]  = '{1'b0, 1'b1, 32'h0000_0040, 32'hCAFE_F00D, 32'h0,        0,    1'b0, 3,  32'h0,        3,  0, 0, -1, 8'h00, 1'b0, 32'h0};
        vecs[3]  = '{1'b1, 1'b0, 32'h0000_0040, 32'h0,        32'h0,         0,    1'b0, 3,  32'hCAFE_F00D, 3,  0, 0, -1, 8'h00, 1'b0, 32'h0};
        vecs[4]  = '{1'b1, 1'b0, 32'h4000_0000, 32'h0,        32'h0,         0,    1'b0, 1,  32'hDEAD_0BAD, 1,  0, 0, -1, 8'h00, 1'b1, 32'h4000_0000};
        vecs[5]  = '{1'b0, 1'b1, 32'h4000_0004, 32'h7,        32'h0,         0,    1'b0, 1,  32'hDEAD_0BAD, 1,  0, 0, -1, 8'h00, 1'b1, 32'h4000_0000};
        vecs[6]  = '{1'b1, 1'b0, 32'h8000_0004, 32'h0,        32'h5A5A_5A5A, 1000, 1'b1, 66, 32'hDEAD_0BAD, 66, 1, 0,  1, 8'h04, 1'b1, 32'h8000_0004};
        vecs[7]  = '{1'b0, 1'b1, 32'h0000_0042, 32'h1111_1111, 32'h0,        0,    1'b0, 1,  32'hDEAD_0BAD, 1,  0, 0, -1, 8'h00, 1'b1, 32'h8000_0004};
        vecs[8]  = '{1'b1, 1'b0, 32'h0000_0040, 32'h0,        32'h0,         0,    1'b0, 3,  32'hCAFE_F00D, 3,  0, 0, -1, 8'h00, 1'b1, 32'h8000_0004};
        vecs[9]  = '{1'b1, 1'b1, 32'h0000_0040, 32'h2222_2222, 32'h0,        0,    1'b0, 1,  32'hDEAD_0BAD, 1,  0, 0, -1, 8'h00, 1'b1, 32'h8000_0004};
        vecs[10] = '{1'b0, 1'b1, 32'h0000_03FC, 32'hA5A5_5A5A, 32'h0,        0,    1'b0, 3,  32'h0,        3,  0, 0, -1, 8'h00, 1'b1, 32'h8000_0004};
        vecs[11] = '{1'b1, 1'b0, 32'h0000_03FC, 32'h0,        32'h0,         0,    1'b0, 3,  32'hA5A5_5A5A, 3,  0, 0, -1, 8'h00, 1'b1, 32'h8000_0004};

        RESET = 1'b1;
        err_clear = 1'b0;
        cpu.DATA_MEM_READ       = 1'b1;
        cpu.DATA_MEM_WRITE      = 1'b0;
        cpu.DATA_MEM_ADDR       = 32'h8000_0010;
        cpu.DATA_MEM_WRITE_DATA = 32'h0;
        nb.nb_read_data = 32'h0;
        nb.nb_ready     = 1'b1;

        // Reset state, with a request pending to show BUSYWAIT is forced low.
        repeat (2) @(posedge CLK);
        #1;
        check("rst busywait", 32'(cpu.DATA_MEM_BUSYWAIT), 32'h0);
        check("rst read_data", cpu.DATA_MEM_READ_DATA, 32'h0);
        check("rst nb_enables", {30'h0, nb.nb_read_enable, nb.nb_write_enable}, 32'h0);
        check("rst nb_address", 32'(nb.nb_address), 32'h0);
        check("rst bus_error", 32'(bus_error), 32'h0);
        check("rst err_addr", err_addr, 32'h0);
        cpu.DATA_MEM_READ = 1'b0;
        @(negedge CLK);
        RESET = 1'b0;
        @(posedge CLK); #1;

        for (int i = 0; i < 12; i++) begin
            v = vecs[i];
            if (v.clr) begin
                err_clear = 1'b1;
                @(posedge CLK); #1;
                err_clear = 1'b0;
                check($sformatf("v%0d clear bus_error", i), 32'(bus_error), 32'h0);
                check($sformatf("v%0d clear err_addr", i), err_addr, 32'h0);
            end
            access(v, dc, dat, bz, rp, wp, pc, pa, pw, bh);
            check($sformatf("v%0d done_cycle", i), 32'(dc), 32'(v.exp_done));
            check($sformatf("v%0d read_data", i), dat, v.exp_data);
            check($sformatf("v%0d busy_cycles", i), 32'(bz), 32'(v.exp_busy));
            check($sformatf("v%0d rd_pulses", i), 32'(rp), 32'(v.exp_rdp));
            check($sformatf("v%0d wr_pulses", i), 32'(wp), 32'(v.exp_wrp));
            check($sformatf("v%0d both_enables", i), 32'(bh), 32'h0);
            if (v.exp_rdp + v.exp_wrp > 0) begin
                check($sformatf("v%0d pulse_cycle", i), 32'(pc), 32'(v.exp_pcyc));
                check($sformatf("v%0d nb_address", i), 32'(pa), 32'(v.exp_paddr));
            end
            if (v.exp_wrp > 0)
                check($sformatf("v%0d nb_write_data", i), pw, v.wd);
            check($sformatf("v%0d bus_error", i), 32'(bus_error), 32'(v.exp_err));
            check($sformatf("v%0d err_addr", i), err_addr, v.exp_eaddr);
        end

        // Reset while waiting on the neuron bank.
        nb.nb_ready       = 1'b0;
        cpu.DATA_MEM_READ = 1'b1;
        cpu.DATA_MEM_ADDR = 32'h8000_0008;
        repeat (3) begin
            @(posedge CLK); #1;
        end
        check("mid busywait before reset", 32'(cpu.DATA_MEM_BUSYWAIT), 32'h1);
        RESET = 1'b1;
        #1;
        check("mid rst busywait", 32'(cpu.DATA_MEM_BUSYWAIT), 32'h0);
        check("mid rst read_data", cpu.DATA_MEM_READ_DATA, 32'h0);
        check("mid rst nb_enables", {30'h0, nb.nb_read_enable, nb.nb_write_enable}, 32'h0);
        check("mid rst nb_address", 32'(nb.nb_address), 32'h0);
        check("mid rst bus_error", 32'(bus_error), 32'h0);
        check("mid rst err_addr", err_addr, 32'h0);
        cpu.DATA_MEM_READ = 1'b0;
        @(negedge CLK);
        RESET = 1'b0;
        @(posedge CLK); #1;

        v = '{1'b1, 1'b0, 32'h8000_000C, 32'h0, 32'h5555_AAAA, 0, 1'b0, 3, 32'h5555_AAAA,
              3, 1, 0, 1, 8'h0C, 1'b0, 32'h0};
        access(v, dc, dat, bz, rp, wp, pc, pa, pw, bh);
        check("post-reset done_cycle", 32'(dc), 32'(v.exp_done));
        check("post-reset read_data", dat, v.exp_data);
        check("post-reset rd_pulses", 32'(rp), 32'(v.exp_rdp));
        check("post-reset nb_address", 32'(pa), 32'(v.exp_paddr));
        check("post-reset bus_error", 32'(bus_error), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
